// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed 4-digit seven-segment scan controller with
// double-buffered frames, anti-ghost blanking and leading-zero suppression.
module sseg_scan_ctrl #(
  parameter int DIGIT_CYC = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        lz_en,
  output logic        ready,
  output logic [3:0]  hex,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);
  localparam int CW = DIGIT_CYC > 1 ? $clog2(DIGIT_CYC) : 1;
  typedef enum logic {BLANK, ON} state_t;
  state_t state, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] digit, dig_nx;
  logic [15:0] act_data, sh_data, data_nx;
  logic [3:0] act_dp, sh_dp, act_blank, sh_blank, dp_nx, blank_nx, zero, off;
  logic pending, last, frame_end, commit;
  assign ready = ~pending;
  assign last = cnt == CW'(DIGIT_CYC - 1);
  assign frame_end = last && digit == 2'd3;
  assign commit = frame_end && pending;
  // Outputs are registered from next-cycle values so they line up with cnt/digit/state.
  always_comb begin
    cnt_nx = last ? '0 : cnt + 1'b1;
    dig_nx = last ? digit + 2'd1 : digit;
    st_nx = cnt == CW'(BLANK_CYC - 1) ? ON : last ? BLANK : state;
    data_nx = commit ? sh_data : act_data;
    dp_nx = commit ? sh_dp : act_dp;
    blank_nx = commit ? sh_blank : act_blank;
    zero[3] = data_nx[15:12] == 4'h0;
    zero[2] = zero[3] && data_nx[11:8] == 4'h0;
    zero[1] = zero[2] && data_nx[7:4] == 4'h0;
    zero[0] = 1'b0;
    off = blank_nx | (lz_en ? zero : 4'h0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      digit <= 2'd0;
      state <= BLANK;
      act_data <= 16'h0;
      act_dp <= 4'h0;
      act_blank <= 4'h0;
      sh_data <= 16'h0;
      sh_dp <= 4'h0;
      sh_blank <= 4'h0;
      pending <= 1'b0;
      frame_tick <= 1'b0;
      hex <= 4'h0;
      dp <= 1'b1;
      an <= 4'hf;
    end else begin
      cnt <= cnt_nx;
      digit <= dig_nx;
      state <= st_nx;
      frame_tick <= frame_end;
      act_data <= data_nx;
      act_dp <= dp_nx;
      act_blank <= blank_nx;
      if (!pending && load) begin
        sh_data <= data_in;
        sh_dp <= dp_in;
        sh_blank <= blank_in;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
      hex <= data_nx[{dig_nx, 2'b00} +: 4];
      dp <= ~dp_nx[dig_nx];
      an <= (st_nx == ON && !off[dig_nx]) ? ~(4'b0001 << dig_nx) : 4'hf;
    end
  end
endmodule
